sram_arbiter: RTL and testbench

Synchronous two-port arbiter and cycle sequencer for the IS61LV256AL 32K×8 asynchronous SRAM (`u_IS61LV256AL`). It accepts byte read/write requests from two clocked requesters and grants them round-robin. It generates registered, glitch-free `nCS`/`nOE`/`nWE` strobes with programmable pulse lengths. It sits between the core's fetch/data ports and the SRAM pins, and is the only driver of the SRAM control lines.

---
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a 32Kx8 async SRAM.
// All SRAM controls come straight from flops so they never glitch.
module sram_arbiter #(
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [14:0] p0_addr,
  input  logic [14:0] p1_addr,
  input  logic [7:0]  p0_wdata,
  input  logic [7:0]  p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [14:0] sram_a,
  output logic [7:0]  sram_d_write,
  input  logic [7:0]  sram_d_read,
  output logic        sram_nCS,
  output logic        sram_nOE,
  output logic        sram_nWE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_WPULSE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] WE_LD = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LD = 4'(RD_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] a_q, a_d;
  logic [7:0]  dw_q, dw_d;
  logic        we_q, we_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ncs_q, ncs_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        win1;
  logic        sel_we;

  // Port 1 wins alone, or on a tie when port 0 was served last.
  assign win1   = p1_req & (~p0_req | ~last_q);
  assign sel_we = win1 ? p1_we : p0_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dw_d    = dw_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (p0_req | p1_req) begin
          gnt_d = win1;
          a_d   = win1 ? p1_addr : p0_addr;
          dw_d  = win1 ? p1_wdata : p0_wdata;
          we_d  = sel_we;
          if (sel_we) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LD;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WPULSE;
        cnt_d   = WE_LD;
      end
      S_WPULSE: begin
        if (cnt_q == 4'd0) state_d = S_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_HOLD: state_d = S_DONE;
      S_READ: begin
        if (cnt_q == 4'd0) begin
          rdata_d = sram_d_read;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe flops are loaded with the values of the state being entered.
  always_comb begin
    ncs_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    noe_d  = (state_d != S_READ);
    nwe_d  = (state_d != S_WPULSE);
    ack0_d = (state_d == S_DONE) && !gnt_d;
    ack1_d = (state_d == S_DONE) && gnt_d;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 15'd0;
      dw_q    <= 8'd0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= 8'd0;
      ncs_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dw_q    <= dw_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      noe_q   <= noe_d;
      nwe_q   <= nwe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign p0_ack       = ack0_q;
  assign p1_ack       = ack1_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != S_IDLE);
  assign sram_a       = a_q;
  assign sram_d_write = dw_q;
  assign sram_nCS     = ncs_q;
  assign sram_nOE     = noe_q;
  assign sram_nWE     = nwe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
// A second instance covers non-default pulse lengths.
module tb_sram_arbiter;

  logic        clk;
  logic        nRESET;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [14:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, busy;
  logic [7:0]  rdata;
  logic [14:0] sram_a;
  logic [7:0]  sram_d_write, sram_d_read;
  logic        sram_nCS, sram_nOE, sram_nWE;

  logic        q_req, q_we;
  logic [14:0] q_addr;
  logic [7:0]  q_wdata;
  logic        q_ack0, q_ack1, q_busy;
  logic [7:0]  q_rdata;
  logic [14:0] q_a;
  logic [7:0]  q_dw, q_dr;
  logic        q_nCS, q_nOE, q_nWE;

  int n_chk;
  int n_fail;
  int a_viol;
  int oe_we_viol;

  logic [7:0] mem  [0:32767];
  logic [7:0] mem2 [0:32767];

  sram_arbiter u_dut (
    .clk(clk), .nRESET(nRESET),
    .p0_req(p0_req), .p1_req(p1_req),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack),
    .rdata(rdata), .busy(busy),
    .sram_a(sram_a), .sram_d_write(sram_d_write),
    .sram_d_read(sram_d_read),
    .sram_nCS(sram_nCS), .sram_nOE(sram_nOE),
    .sram_nWE(sram_nWE)
  );

  sram_arbiter #(.WE_CYCLES(1), .RD_CYCLES(4)) u_dut2 (
    .clk(clk), .nRESET(nRESET),
    .p0_req(q_req), .p1_req(1'b0),
    .p0_we(q_we), .p1_we(1'b0),
    .p0_addr(q_addr), .p1_addr(15'd0),
    .p0_wdata(q_wdata), .p1_wdata(8'd0),
    .p0_ack(q_ack0), .p1_ack(q_ack1),
    .rdata(q_rdata), .busy(q_busy),
    .sram_a(q_a), .sram_d_write(q_dw),
    .sram_d_read(q_dr),
    .sram_nCS(q_nCS), .sram_nOE(q_nOE),
    .sram_nWE(q_nWE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
  end

  always @(posedge sram_nWE)
    if (!sram_nCS && nRESET) mem[sram_a] = sram_d_write;
  always @(posedge q_nWE)
    if (!q_nCS && nRESET) mem2[q_a] = q_dw;

  assign sram_d_read = (!sram_nCS && !sram_nOE) ? mem[sram_a] : 8'h00;
  assign q_dr        = (!q_nCS && !q_nOE) ? mem2[q_a] : 8'h00;

  always @(sram_a) if (!sram_nWE) a_viol++;
  always @(negedge clk) if (!sram_nOE && !sram_nWE) oe_we_viol++;

  task automatic do_access(input int port, input logic we,
                           input logic [14:0] addr, input logic [7:0] wd,
                           output int lat, output int nwe_lo,
                           output int noe_lo, output int bad_ack);
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
    end
    lat = -1; nwe_lo = 0; noe_lo = 0; bad_ack = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!sram_nWE) nwe_lo++;
      if (!sram_nOE) noe_lo++;
      if ((port == 0) ? p1_ack : p0_ack) bad_ack++;
      if ((port == 0) ? p0_ack : p1_ack) begin
        lat = i;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_access2(input logic we, input logic [14:0] addr,
                            input logic [7:0] wd, output int lat,
                            output int nwe_lo);
    q_we = we; q_addr = addr; q_wdata = wd; q_req = 1'b1;
    lat = -1; nwe_lo = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!q_nWE) nwe_lo++;
      if (q_ack0) begin
        lat = i;
        break;
      end
    end
    q_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    p0_we = 1'b0; p0_addr = 15'h0005; p0_wdata = 8'h00; p0_req = 1'b1;
    nRESET = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sram_nCS, sram_nOE, sram_nWE} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_strobes: got %b want 111",
               {sram_nCS, sram_nOE, sram_nWE});
    end
    n_chk++;
    if ({p0_ack, p1_ack, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_ack_busy: got %b want 000", {p0_ack, p1_ack, busy});
    end
    n_chk++;
    if (sram_a !== 15'd0 || rdata !== 8'd0 || sram_d_write !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_regs: a=%h d=%h r=%h want 0", sram_a,
               sram_d_write, rdata);
    end
    nRESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || sram_a !== 15'h0005 || sram_nOE !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_first_edge: busy=%b a=%h nOE=%b want 1 0005 0",
               busy, sram_a, sram_nOE);
    end
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (p0_ack) begin
        lat = i;
        break;
      end
    end
    p0_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL rst_read_lat: got %0d want 3", lat);
    end
  endtask

  task automatic test_single();
    int lat, nwe_lo, noe_lo, bad;
    do_access(0, 1'b1, 15'h0064, 8'hFA, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL wr_lat: got %0d want 5", lat);
    end
    n_chk++;
    if (nwe_lo !== 2 || noe_lo !== 0) begin
      n_fail++;
      $display("FAIL wr_strobes: nWE low %0d nOE low %0d want 2 0",
               nwe_lo, noe_lo);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL wr_other_ack: got %0d want 0", bad);
    end
    do_access(0, 1'b0, 15'h0064, 8'h00, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL rd_lat: got %0d want 3", lat);
    end
    n_chk++;
    if (rdata !== 8'hFA) begin
      n_fail++;
      $display("FAIL rd_data: got %h want fa", rdata);
    end
    n_chk++;
    if (noe_lo !== 2 || nwe_lo !== 0) begin
      n_fail++;
      $display("FAIL rd_strobes: nOE low %0d nWE low %0d want 2 0",
               noe_lo, nwe_lo);
    end
  endtask

  task automatic test_simultaneous();
    int exp_w [4] = '{0, 1, 0, 1};
    int win;
    bit got;
    nRESET = 1'b0;
    @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    p0_we = 1'b0; p0_addr = 15'h0064;
    p1_we = 1'b0; p1_addr = 15'h0010;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (p0_ack || p1_ack) begin
          got = 1'b1;
          break;
        end
      end
      n_chk++;
      if (!got) begin
        n_fail++;
        $display("FAIL sim_timeout: grant %0d got none want ack", g);
        break;
      end
      n_chk++;
      if (p0_ack && p1_ack) begin
        n_fail++;
        $display("FAIL sim_dual_ack: got 11 want one-hot");
      end
      win = p1_ack ? 1 : 0;
      n_chk++;
      if (win !== exp_w[g]) begin
        n_fail++;
        $display("FAIL sim_order: grant %0d got p%0d want p%0d",
                 g, win, exp_w[g]);
      end
      n_chk++;
      if (rdata !== ((win == 0) ? 8'hFA : 8'h00)) begin
        n_fail++;
        $display("FAIL sim_rdata: grant %0d got %h", g, rdata);
      end
      if (win == 0) p0_req = 1'b0;
      else          p1_req = 1'b0;
      @(negedge clk);
      if (g < 2) begin
        if (win == 0) p0_req = 1'b1;
        else          p1_req = 1'b1;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, nwe_lo, noe_lo, bad, v0;
    v0 = a_viol;
    do_access(1, 1'b1, 15'h7FFF, 8'h55, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (lat !== 5 || bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_wr1: lat %0d bad %0d want 5 0", lat, bad);
    end
    do_access(1, 1'b1, 15'h0000, 8'hAA, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (lat !== 5 || bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_wr2: lat %0d bad %0d want 5 0", lat, bad);
    end
    do_access(1, 1'b0, 15'h7FFF, 8'h00, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (rdata !== 8'h55) begin
      n_fail++;
      $display("FAIL b2b_rd_7fff: got %h want 55", rdata);
    end
    do_access(0, 1'b0, 15'h0000, 8'h00, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (rdata !== 8'hAA) begin
      n_fail++;
      $display("FAIL b2b_rd_0000: got %h want aa", rdata);
    end
    n_chk++;
    if (a_viol !== v0) begin
      n_fail++;
      $display("FAIL b2b_addr_during_nwe: got %0d changes want 0",
               a_viol - v0);
    end
    n_chk++;
    if (oe_we_viol !== 0) begin
      n_fail++;
      $display("FAIL oe_we_overlap: got %0d want 0", oe_we_viol);
    end
  endtask

  task automatic test_params();
    int lat, nwe_lo;
    do_access2(1'b1, 15'h0020, 8'h3C, lat, nwe_lo);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL par_wr_lat: got %0d want 4", lat);
    end
    n_chk++;
    if (nwe_lo !== 1) begin
      n_fail++;
      $display("FAIL par_nwe_len: got %0d want 1", nwe_lo);
    end
    do_access2(1'b0, 15'h0020, 8'h00, lat, nwe_lo);
    n_chk++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL par_rd_lat: got %0d want 5", lat);
    end
    n_chk++;
    if (q_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL par_rd_data: got %h want 3c", q_rdata);
    end
  endtask

  task automatic test_mid_reset();
    int lat, nwe_lo, noe_lo, bad, acks;
    bit hit;
    do_access(0, 1'b1, 15'h0101, 8'h11, lat, nwe_lo, noe_lo, bad);
    p0_we = 1'b1; p0_addr = 15'h0100; p0_wdata = 8'h99; p0_req = 1'b1;
    @(posedge clk);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sram_nWE) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_no_wpulse: got nWE=1 want 0");
    end
    nRESET = 1'b0;
    #1;
    n_chk++;
    if ({sram_nCS, sram_nOE, sram_nWE, busy} !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_strobes: got %b want 1110",
               {sram_nCS, sram_nOE, sram_nWE, busy});
    end
    p0_req = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    nRESET = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    n_chk++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL mid_ack: got %0d acks want 0", acks);
    end
    do_access(0, 1'b0, 15'h0101, 8'h00, lat, nwe_lo, noe_lo, bad);
    n_chk++;
    if (rdata !== 8'h11 || lat !== 3) begin
      n_fail++;
      $display("FAIL mid_neighbour: got %h lat %0d want 11 lat 3",
               rdata, lat);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; a_viol = 0; oe_we_viol = 0;
    nRESET = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    q_req = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_params();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
